tx_char_scheduler: RTL and testbench
====================================

# tx_char_scheduler

Selects the next SpaceWire character type on the transmit side and drives the one-hot `state_tx` code consumed by the transmit data/serializer path. It applies the ECSS-E-ST-50-12C priority order (Time-Code > FCT > N-Char > NULL) at each character boundary. It also owns the transmit credit counter, the owed-FCT counter and the one-entry data/time-code holding registers. It sits between the link-level FSM and host FIFO on one side and the transmit data path on the other.

## Interface
Parameters:
- `MAX_CREDIT`, 56: transmit credit ceiling (7 FCTs × 8).
- `MAX_OWED`, 7: owed-FCT counter ceiling.

Ports:
- `pclk_tx` in 1: transmit clock. This is the only clock.
- `reset_tx` in 1: asynchronous, active-high reset.
- `link_mode` in 2: 0 idle, 1 started, 2 connecting, 3 run.
- `char_done` in 1: one-cycle pulse when the serializer has sent the last bit of the current character.
- `tickin_tx` in 1: time-code request.
- `timecode_tx_i` in 8: time-code value, sampled with `tickin_tx`.
- `txwrite_tx` in 1: host data valid.
- `data_tx_i` in 9: N-Char; bit 8 = 1 marks EOP/EEP.
- `fct_owed_inc` in 1: receiver freed 8 slots, so one more FCT is owed.
- `fct_rx` in 1: FCT received from the link, worth +8 credits.
- `state_tx` out 7: one-hot code. start 0000000, null 0000001, fct 0000010, null_c 0000100, fct_c 0001000, data_c 0010000, data_c_0 0100000, time_code_c 1000000.
- `tx_char_data` out 9: N-Char for the current data state.
- `tx_tcode` out 8: time-code for time_code_c.
- `txrdy_tx` out 1: holding register empty and able to accept data.
- `tickin_ack` out 1: one-cycle acknowledge that a tick was latched.
- `credit_count` out 6: current credit.
- `credit_error` out 1: one-cycle pulse on credit overflow.

## Operation
- Reset values: `state_tx` = start; all counters, holding registers and flags = 0; `txrdy_tx` = 0.
- Leaving start: when `link_mode` != 0 and the state is start, move to null on the next cycle without waiting for `char_done`.
- All other state changes happen only on the cycle following `char_done`.
- Next-state selection at `char_done`, by `link_mode`:
  - idle: start.
  - started: null.
  - connecting: fct if owed > 0, else null.
  - run: time_code_c if a tick is pending; else fct_c if owed > 0; else a data state if data is valid and credit > 0; else null_c.
- Data states alternate on successive N-Chars: data_c, then data_c_0, then data_c, and so on. The toggle bit resets to "next = data_c". It is not reset by intervening NULL, FCT or time-code characters.
- Data handshake:
  - `txrdy_tx` = !data_valid && link_mode == 3.
  - The holding register loads when `txwrite_tx && txrdy_tx`.
  - `data_valid` clears when a data state is selected. `tx_char_data` holds the value for that character.
- Ticks:
  - `tickin_tx` is accepted only in run with no tick pending. It latches `timecode_tx_i` and pulses `tickin_ack`.
  - A tick that arrives while one is already pending is dropped, with no ack.
  - Selecting time_code_c clears the pending flag.
- Credit:
  - `fct_rx` adds 8. Selecting a data state subtracts 1.
  - If `fct_rx` and a data-state selection occur in the same cycle, the net change is +7.
  - If the result would exceed `MAX_CREDIT`, `credit_error` pulses and the +8 is discarded; the −1 still applies.
- Owed FCTs:
  - `fct_owed_inc` adds 1, saturating at `MAX_OWED`. Selecting fct or fct_c subtracts 1.
  - If both occur in the same cycle, the count is unchanged.
- `link_mode` falling to 0 forces start on the next cycle, regardless of `char_done`. It also clears credit, owed count, the tick-pending flag, `data_valid` and the toggle bit.

## Timing
- Decision latency: 1 cycle from `char_done` to the new `state_tx`. Output registers update in the same edge.
- `txrdy_tx` is derived combinationally from registered state only, with no input-to-output path.
- `tickin_ack` and `credit_error` are single-cycle pulses, registered.
- When `reset_tx` is asserted mid-character, all outputs take their reset values immediately (asynchronously).

## Structure
- Shared package `spw_tx_pkg`: the 7-bit `state_tx` codes, the `link_mode` encodings, `MAX_CREDIT` and `MAX_OWED`. The transmit data path imports the same codes.
- One natural sub-module, `tx_credit_counter`. It implements the credit add/subtract/overflow rules and the owed-FCT saturating counter.

## Test plan
- Reset, then `link_mode` = 1 with `char_done` every 10 cycles: `state_tx` goes start → null and stays null. `txrdy_tx` = 0.
- Connecting with 3 `fct_owed_inc` pulses: the next three characters are fct and the fourth is null. Owed count reaches 0.
- Run with credit 0 and data valid: only null_c is sent. One `fct_rx` gives credit 8; the next 8 characters alternate data_c/data_c_0 and credit returns to 0.
- Run with a tick, an owed FCT and valid data all pending at one `char_done`: the sequence is time_code_c, fct_c, data_c. `tx_tcode` equals the latched value (e.g. 0x3F).
- Credit 50 with `fct_rx`: `credit_error` pulses and credit stays 50. Credit 49 with `fct_rx` and a simultaneous data selection: credit becomes 56 and there is no error.
- Drop `link_mode` to 0 mid-run: `state_tx` becomes start within 1 cycle and counters are 0. Assert `reset_tx` asynchronously mid-character: outputs clear before the next edge.

Source files
------------

// File: rtl/spw_tx_pkg.sv
// ---------------------------------------------------------------------------
// spw_tx_pkg
// Shared constants for the SpaceWire transmit side: the one-hot state_tx
// character codes (also decoded by the transmit data path), the link_mode
// encodings driven by the link FSM, and the flow-control ceilings.
// ---------------------------------------------------------------------------
package spw_tx_pkg;

  // state_tx character codes
  localparam logic [6:0] ST_START  = 7'b0000000;
  localparam logic [6:0] ST_NULL   = 7'b0000001;
  localparam logic [6:0] ST_FCT    = 7'b0000010;
  localparam logic [6:0] ST_NULL_C = 7'b0000100;
  localparam logic [6:0] ST_FCT_C  = 7'b0001000;
  localparam logic [6:0] ST_DATA_C = 7'b0010000;
  localparam logic [6:0] ST_DATA_C0 = 7'b0100000;
  localparam logic [6:0] ST_TIME_C = 7'b1000000;

  // link_mode encodings
  localparam logic [1:0] LM_IDLE       = 2'd0;
  localparam logic [1:0] LM_STARTED    = 2'd1;
  localparam logic [1:0] LM_CONNECTING = 2'd2;
  localparam logic [1:0] LM_RUN        = 2'd3;

  // Flow control: each FCT is worth 8 N-Chars, at most 7 FCTs outstanding
  localparam int FCT_CREDIT     = 8;
  localparam int SPW_MAX_CREDIT = 56;
  localparam int SPW_MAX_OWED   = 7;

endpackage

// File: rtl/tx_credit_counter.sv
// ---------------------------------------------------------------------------
// tx_credit_counter
// Transmit credit counter and owed-FCT counter.
//   pclk_tx, reset_tx : clock, asynchronous active-high reset
//   clear             : link left the active modes, zero both counters
//   fct_rx            : FCT received, +FCT_CREDIT credits
//   credit_take       : an N-Char was scheduled, -1 credit
//   fct_owed_inc      : receiver freed a buffer block, one more FCT owed
//   fct_sent          : an FCT was scheduled, one less owed
//   credit_count      : current credit
//   owed_count        : FCTs still owed to the far end
//   credit_error      : registered one-cycle pulse on credit overflow
// ---------------------------------------------------------------------------
module tx_credit_counter
  import spw_tx_pkg::*;
#(
  parameter int MAX_CREDIT = SPW_MAX_CREDIT,
  parameter int MAX_OWED   = SPW_MAX_OWED,
  parameter int OWED_W     = 3
) (
  input  logic              pclk_tx,
  input  logic              reset_tx,
  input  logic              clear,
  input  logic              fct_rx,
  input  logic              credit_take,
  input  logic              fct_owed_inc,
  input  logic              fct_sent,
  output logic [5:0]        credit_count,
  output logic [OWED_W-1:0] owed_count,
  output logic              credit_error
);

  localparam logic [OWED_W-1:0] OWED_CAP = OWED_W'(MAX_OWED);

  logic [6:0]        credit_sum;
  logic              credit_ovf;
  logic [5:0]        credit_nxt;
  logic [OWED_W-1:0] owed_nxt;

  always_comb begin
    // The overflow test is on the net result, so +8 and -1 in the same
    // cycle may land exactly on the ceiling without an error.
    credit_sum = {1'b0, credit_count} + (fct_rx ? 7'(FCT_CREDIT) : 7'd0)
                 - {6'd0, credit_take};
    credit_ovf = fct_rx && (credit_sum > 7'(MAX_CREDIT));
    // On overflow the +8 is dropped but the N-Char still consumes its credit.
    credit_nxt = credit_ovf ? (credit_count - {5'd0, credit_take}) : credit_sum[5:0];

    owed_nxt = owed_count;
    if (fct_owed_inc && !fct_sent) begin
      if (owed_count != OWED_CAP) owed_nxt = owed_count + 1'b1;
    end else if (fct_sent && !fct_owed_inc) begin
      if (owed_count != '0) owed_nxt = owed_count - 1'b1;
    end
  end

  always_ff @(posedge pclk_tx or posedge reset_tx) begin
    if (reset_tx) begin
      credit_count <= '0;
      owed_count   <= '0;
      credit_error <= 1'b0;
    end else if (clear) begin
      credit_count <= '0;
      owed_count   <= '0;
      credit_error <= 1'b0;
    end else begin
      credit_count <= credit_nxt;
      owed_count   <= owed_nxt;
      credit_error <= credit_ovf;
    end
  end

endmodule

// File: rtl/tx_char_scheduler.sv
// ---------------------------------------------------------------------------
// tx_char_scheduler
// Chooses the next SpaceWire character at every character boundary with the
// priority Time-Code > FCT > N-Char > NULL and drives the one-hot state_tx
// code for the transmit data path. Owns the one-entry data and time-code
// holding registers; credit/owed counting lives in tx_credit_counter.
//   pclk_tx, reset_tx : clock, asynchronous active-high reset
//   link_mode         : 0 idle, 1 started, 2 connecting, 3 run
//   char_done         : serializer finished the current character
//   tickin_tx, timecode_tx_i : time-code request and value
//   txwrite_tx, data_tx_i    : host N-Char write (bit 8 = EOP/EEP)
//   fct_owed_inc, fct_rx     : flow-control events
//   state_tx          : one-hot character code
//   tx_char_data      : N-Char of the current data character
//   tx_tcode          : time-code of the current time-code character
//   txrdy_tx          : holding register can take a host write
//   tickin_ack        : tick latched (one-cycle pulse)
//   credit_count, credit_error : credit state and overflow pulse
// ---------------------------------------------------------------------------
module tx_char_scheduler
  import spw_tx_pkg::*;
#(
  parameter int MAX_CREDIT = SPW_MAX_CREDIT,
  parameter int MAX_OWED   = SPW_MAX_OWED
) (
  input  logic       pclk_tx,
  input  logic       reset_tx,
  input  logic [1:0] link_mode,
  input  logic       char_done,
  input  logic       tickin_tx,
  input  logic [7:0] timecode_tx_i,
  input  logic       txwrite_tx,
  input  logic [8:0] data_tx_i,
  input  logic       fct_owed_inc,
  input  logic       fct_rx,
  output logic [6:0] state_tx,
  output logic [8:0] tx_char_data,
  output logic [7:0] tx_tcode,
  output logic       txrdy_tx,
  output logic       tickin_ack,
  output logic [5:0] credit_count,
  output logic       credit_error
);

  localparam int OWED_W = $clog2(MAX_OWED + 1);

  logic              run_q;       // link_mode was run at the last edge
  logic              data_valid;
  logic [8:0]        data_buf;
  logic              tick_pend;
  logic [7:0]        tcode_buf;
  logic              next_data0;  // next N-Char goes out as data_c_0
  logic [OWED_W-1:0] owed_count;

  logic [6:0] state_nxt;
  logic       sel_fct;
  logic       sel_data;
  logic       sel_time;
  logic       lm_clear;
  logic       tick_accept;
  logic       data_load;

  // Registered terms only, so the host handshake has no input-to-output path.
  assign txrdy_tx = !data_valid && run_q;

  always_comb begin
    state_nxt   = state_tx;
    sel_fct     = 1'b0;
    sel_data    = 1'b0;
    sel_time    = 1'b0;
    lm_clear    = (link_mode == LM_IDLE);
    tick_accept = tickin_tx && (link_mode == LM_RUN) && !tick_pend;
    data_load   = txwrite_tx && txrdy_tx;

    if (state_tx == ST_START) begin
      // start has no character in flight, so it leaves immediately
      state_nxt = ST_NULL;
    end else if (char_done) begin
      case (link_mode)
        LM_IDLE:    state_nxt = ST_START;
        LM_STARTED: state_nxt = ST_NULL;
        LM_CONNECTING: begin
          if (owed_count != '0) begin
            state_nxt = ST_FCT;
            sel_fct   = 1'b1;
          end else begin
            state_nxt = ST_NULL;
          end
        end
        default: begin
          if (tick_pend) begin
            state_nxt = ST_TIME_C;
            sel_time  = 1'b1;
          end else if (owed_count != '0) begin
            state_nxt = ST_FCT_C;
            sel_fct   = 1'b1;
          end else if (data_valid && (credit_count != 6'd0)) begin
            state_nxt = next_data0 ? ST_DATA_C0 : ST_DATA_C;
            sel_data  = 1'b1;
          end else begin
            state_nxt = ST_NULL_C;
          end
        end
      endcase
    end
  end

  tx_credit_counter #(
    .MAX_CREDIT (MAX_CREDIT),
    .MAX_OWED   (MAX_OWED),
    .OWED_W     (OWED_W)
  ) u_credit (
    .pclk_tx      (pclk_tx),
    .reset_tx     (reset_tx),
    .clear        (lm_clear),
    .fct_rx       (fct_rx),
    .credit_take  (sel_data),
    .fct_owed_inc (fct_owed_inc),
    .fct_sent     (sel_fct),
    .credit_count (credit_count),
    .owed_count   (owed_count),
    .credit_error (credit_error)
  );

  always_ff @(posedge pclk_tx or posedge reset_tx) begin
    if (reset_tx) begin
      state_tx     <= ST_START;
      run_q        <= 1'b0;
      data_valid   <= 1'b0;
      data_buf     <= '0;
      tick_pend    <= 1'b0;
      tcode_buf    <= '0;
      next_data0   <= 1'b0;
      tx_char_data <= '0;
      tx_tcode     <= '0;
      tickin_ack   <= 1'b0;
    end else begin
      tickin_ack <= tick_accept;
      if (lm_clear) begin
        // Link dropped: abandon everything pending, keep last output values.
        state_tx   <= ST_START;
        run_q      <= 1'b0;
        data_valid <= 1'b0;
        tick_pend  <= 1'b0;
        next_data0 <= 1'b0;
      end else begin
        state_tx <= state_nxt;
        run_q    <= (link_mode == LM_RUN);

        // Load and select are exclusive: loading needs an empty register.
        if (data_load) begin
          data_valid <= 1'b1;
          data_buf   <= data_tx_i;
        end else if (sel_data) begin
          data_valid   <= 1'b0;
          tx_char_data <= data_buf;
          next_data0   <= !next_data0;
        end

        if (tick_accept) begin
          tick_pend <= 1'b1;
          tcode_buf <= timecode_tx_i;
        end else if (sel_time) begin
          tick_pend <= 1'b0;
          tx_tcode  <= tcode_buf;
        end
      end
    end
  end

endmodule

// File: tb/tb_tx_char_scheduler.sv
module tb_tx_char_scheduler;

  localparam logic [6:0] S_START  = 7'b0000000;
  localparam logic [6:0] S_NULL   = 7'b0000001;
  localparam logic [6:0] S_FCT    = 7'b0000010;
  localparam logic [6:0] S_NULL_C = 7'b0000100;
  localparam logic [6:0] S_FCT_C  = 7'b0001000;
  localparam logic [6:0] S_DATA_C = 7'b0010000;
  localparam logic [6:0] S_DATA_C0 = 7'b0100000;
  localparam logic [6:0] S_TIME_C = 7'b1000000;

  logic       pclk_tx = 1'b0;
  logic       reset_tx;
  logic [1:0] link_mode;
  logic       char_done;
  logic       tickin_tx;
  logic [7:0] timecode_tx_i;
  logic       txwrite_tx;
  logic [8:0] data_tx_i;
  logic       fct_owed_inc;
  logic       fct_rx;
  logic [6:0] state_tx;
  logic [8:0] tx_char_data;
  logic [7:0] tx_tcode;
  logic       txrdy_tx;
  logic       tickin_ack;
  logic [5:0] credit_count;
  logic       credit_error;

  int checks = 0;
  int failures = 0;

  tx_char_scheduler dut (
    .pclk_tx       (pclk_tx),
    .reset_tx      (reset_tx),
    .link_mode     (link_mode),
    .char_done     (char_done),
    .tickin_tx     (tickin_tx),
    .timecode_tx_i (timecode_tx_i),
    .txwrite_tx    (txwrite_tx),
    .data_tx_i     (data_tx_i),
    .fct_owed_inc  (fct_owed_inc),
    .fct_rx        (fct_rx),
    .state_tx      (state_tx),
    .tx_char_data  (tx_char_data),
    .tx_tcode      (tx_tcode),
    .txrdy_tx      (txrdy_tx),
    .tickin_ack    (tickin_ack),
    .credit_count  (credit_count),
    .credit_error  (credit_error)
  );

  always #5 pclk_tx = ~pclk_tx;

  // ---------------- reference model (character-kind level) ----------------
  // kind: 0 start, 1 null, 2 fct, 3 null_c, 4 fct_c, 5 data_c, 6 data_c_0, 7 time_code_c
  typedef struct packed {
    logic [2:0] kind;
    logic [6:0] credit;
    logic [3:0] owed;
    logic       pend;
    logic [7:0] tlat;
    logic [7:0] tout;
    logic       dv;
    logic [8:0] dbuf;
    logic [8:0] dout;
    logic       par;
    logic       run;
    logic       ack;
    logic       err;
  } mstate_t;

  mstate_t m;

  function automatic logic [6:0] kind_code(input logic [2:0] k);
    case (k)
      3'd1: return S_NULL;
      3'd2: return S_FCT;
      3'd3: return S_NULL_C;
      3'd4: return S_FCT_C;
      3'd5: return S_DATA_C;
      3'd6: return S_DATA_C0;
      3'd7: return S_TIME_C;
      default: return S_START;
    endcase
  endfunction

  function automatic mstate_t model_next(input mstate_t c, input logic [1:0] lm,
      input logic cd, input logic tk, input logic [7:0] tc, input logic wr,
      input logic [8:0] d, input logic oi, input logic fr);
    mstate_t n = c;
    int pick = int'(c.kind);
    int cr;
    logic decided = cd && (c.kind != 3'd0);
    logic snd_data, snd_fct, snd_time;
    n.ack = 1'b0;
    n.err = 1'b0;
    if (lm == 2'd0) begin
      n.kind = 3'd0; n.credit = '0; n.owed = '0; n.pend = 1'b0;
      n.dv = 1'b0; n.par = 1'b0; n.run = 1'b0;
      return n;
    end
    if (c.kind == 3'd0) pick = 1;
    else if (cd) begin
      if (lm == 2'd1) pick = 1;
      else if (lm == 2'd2) pick = (c.owed > 0) ? 2 : 1;
      else if (c.pend) pick = 7;
      else if (c.owed > 0) pick = 4;
      else if (c.dv && c.credit > 0) pick = c.par ? 6 : 5;
      else pick = 3;
    end
    n.kind   = 3'(pick);
    snd_data = decided && (pick == 5 || pick == 6);
    snd_fct  = decided && (pick == 2 || pick == 4);
    snd_time = decided && (pick == 7);
    cr = int'(c.credit) + (fr ? 8 : 0) - (snd_data ? 1 : 0);
    if (fr && cr > 56) begin
      n.err = 1'b1;
      cr = int'(c.credit) - (snd_data ? 1 : 0);
    end
    n.credit = 7'(cr);
    if (oi && !snd_fct) n.owed = (c.owed < 4'd7) ? c.owed + 4'd1 : 4'd7;
    else if (snd_fct && !oi) n.owed = c.owed - 4'd1;
    if (tk && lm == 2'd3 && !c.pend) begin
      n.pend = 1'b1; n.tlat = tc; n.ack = 1'b1;
    end
    if (snd_time) begin
      n.pend = 1'b0; n.tout = c.tlat;
    end
    if (wr && !c.dv && c.run) begin
      n.dv = 1'b1; n.dbuf = d;
    end
    if (snd_data) begin
      n.dv = 1'b0; n.dout = c.dbuf; n.par = !c.par;
    end
    n.run = (lm == 2'd3);
    return n;
  endfunction

  always @(posedge pclk_tx or posedge reset_tx) begin
    if (reset_tx) m <= '0;
    else m <= model_next(m, link_mode, char_done, tickin_tx, timecode_tx_i,
                         txwrite_tx, data_tx_i, fct_owed_inc, fct_rx);
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge pclk_tx);
    #1;
    char_done = 1'b0; tickin_tx = 1'b0; txwrite_tx = 1'b0;
    fct_owed_inc = 1'b0; fct_rx = 1'b0;
  endtask

  task automatic send_data(input logic [8:0] v, input logic load,
                           input logic [6:0] exp_st, input int exp_cr);
    if (load) begin
      chk("txrdy_before_load", 64'(txrdy_tx), 64'(1'b1));
      txwrite_tx = 1'b1; data_tx_i = v;
      cyc();
    end
    char_done = 1'b1;
    cyc();
    chk("data_state", 64'(state_tx), 64'(exp_st));
    chk("data_value", 64'(tx_char_data), 64'(v));
    chk("data_credit", 64'(credit_count), 64'(exp_cr));
  endtask

  typedef struct {
    logic [1:0] lm;
    logic       cd;
    logic       inc;
    logic [6:0] st;
    logic       rdy;
    logic [5:0] cr;
  } vec_t;

  vec_t tbl[15];

  initial begin
    logic [32:0] got_v, exp_v;
    int shown = 0;

    tbl[0]  = '{2'd0, 1'b0, 1'b0, S_START,  1'b0, 6'd0};
    tbl[1]  = '{2'd1, 1'b0, 1'b0, S_NULL,   1'b0, 6'd0};
    tbl[2]  = '{2'd1, 1'b1, 1'b0, S_NULL,   1'b0, 6'd0};
    tbl[3]  = '{2'd1, 1'b0, 1'b0, S_NULL,   1'b0, 6'd0};
    tbl[4]  = '{2'd2, 1'b0, 1'b1, S_NULL,   1'b0, 6'd0};
    tbl[5]  = '{2'd2, 1'b0, 1'b1, S_NULL,   1'b0, 6'd0};
    tbl[6]  = '{2'd2, 1'b0, 1'b1, S_NULL,   1'b0, 6'd0};
    tbl[7]  = '{2'd2, 1'b1, 1'b0, S_FCT,    1'b0, 6'd0};
    tbl[8]  = '{2'd2, 1'b1, 1'b0, S_FCT,    1'b0, 6'd0};
    tbl[9]  = '{2'd2, 1'b1, 1'b0, S_FCT,    1'b0, 6'd0};
    tbl[10] = '{2'd2, 1'b1, 1'b0, S_NULL,   1'b0, 6'd0};
    tbl[11] = '{2'd2, 1'b1, 1'b0, S_NULL,   1'b0, 6'd0};
    tbl[12] = '{2'd3, 1'b0, 1'b0, S_NULL,   1'b1, 6'd0};
    tbl[13] = '{2'd3, 1'b1, 1'b0, S_NULL_C, 1'b1, 6'd0};
    tbl[14] = '{2'd0, 1'b0, 1'b0, S_START,  1'b0, 6'd0};

    reset_tx = 1'b1; link_mode = 2'd0; char_done = 1'b0; tickin_tx = 1'b0;
    timecode_tx_i = 8'h00; txwrite_tx = 1'b0; data_tx_i = 9'h000;
    fct_owed_inc = 1'b0; fct_rx = 1'b0;
    cyc(); cyc();
    chk("reset_state", 64'(state_tx), 64'(S_START));
    chk("reset_txrdy", 64'(txrdy_tx), 64'(1'b0));
    chk("reset_credit", 64'(credit_count), 64'(6'd0));
    chk("reset_flags", 64'({tickin_ack, credit_error}), 64'(2'b00));
    reset_tx = 1'b0;

    // link bring-up and connecting-mode FCTs
    for (int i = 0; i < 15; i++) begin
      link_mode = tbl[i].lm; char_done = tbl[i].cd; fct_owed_inc = tbl[i].inc;
      cyc();
      chk($sformatf("tbl%0d_state", i), 64'(state_tx), 64'(tbl[i].st));
      chk($sformatf("tbl%0d_txrdy", i), 64'(txrdy_tx), 64'(tbl[i].rdy));
      chk($sformatf("tbl%0d_credit", i), 64'(credit_count), 64'(tbl[i].cr));
    end

    // run with no credit, then one FCT's worth of alternating data
    link_mode = 2'd3; cyc();
    chk("run_enter", 64'(state_tx), 64'(S_NULL));
    txwrite_tx = 1'b1; data_tx_i = 9'h0A0; cyc();
    chk("held_txrdy", 64'(txrdy_tx), 64'(1'b0));
    char_done = 1'b1; cyc();
    chk("no_credit_null_c", 64'(state_tx), 64'(S_NULL_C));
    fct_rx = 1'b1; cyc();
    chk("fct_rx_credit", 64'(credit_count), 64'(6'd8));
    for (int i = 0; i < 8; i++)
      send_data(9'h0A0 + 9'(i), i > 0, (i % 2 == 1) ? S_DATA_C0 : S_DATA_C, 7 - i);
    char_done = 1'b1; cyc();
    chk("drained_null_c", 64'(state_tx), 64'(S_NULL_C));

    // tick, owed FCT and data all pending at one boundary
    fct_rx = 1'b1; cyc();
    txwrite_tx = 1'b1; data_tx_i = 9'h1FF;
    tickin_tx = 1'b1; timecode_tx_i = 8'h3F; fct_owed_inc = 1'b1; cyc();
    chk("tick_ack", 64'(tickin_ack), 64'(1'b1));
    tickin_tx = 1'b1; timecode_tx_i = 8'h11; cyc();
    chk("tick_drop_noack", 64'(tickin_ack), 64'(1'b0));
    char_done = 1'b1; cyc();
    chk("prio_time", 64'(state_tx), 64'(S_TIME_C));
    chk("tcode_value", 64'(tx_tcode), 64'(8'h3F));
    char_done = 1'b1; cyc();
    chk("prio_fct", 64'(state_tx), 64'(S_FCT_C));
    send_data(9'h1FF, 1'b0, S_DATA_C, 7);
    char_done = 1'b1; cyc();
    chk("prio_idle", 64'(state_tx), 64'(S_NULL_C));
    chk("tcode_kept", 64'(tx_tcode), 64'(8'h3F));

    // link drop clears owed, pending tick and credit
    fct_owed_inc = 1'b1; tickin_tx = 1'b1; timecode_tx_i = 8'h55; cyc();
    chk("tick_ack2", 64'(tickin_ack), 64'(1'b1));
    link_mode = 2'd0; cyc();
    chk("drop_state", 64'(state_tx), 64'(S_START));
    chk("drop_credit", 64'(credit_count), 64'(6'd0));
    chk("drop_txrdy", 64'(txrdy_tx), 64'(1'b0));
    link_mode = 2'd3; cyc();
    chk("rerun_null", 64'(state_tx), 64'(S_NULL));
    txwrite_tx = 1'b1; data_tx_i = 9'h022; cyc();
    char_done = 1'b1; cyc();
    chk("drop_cleared_pending", 64'(state_tx), 64'(S_NULL_C));

    // credit ceiling
    for (int i = 0; i < 7; i++) begin fct_rx = 1'b1; cyc(); end
    chk("credit_full", 64'({credit_error, credit_count}), 64'({1'b0, 6'd56}));
    fct_rx = 1'b1; cyc();
    chk("ovf56", 64'({credit_error, credit_count}), 64'({1'b1, 6'd56}));
    cyc();
    chk("ovf_pulse_end", 64'(credit_error), 64'(1'b0));
    for (int i = 0; i < 6; i++)
      send_data(9'h022 + 9'(i), i > 0, (i % 2 == 1) ? S_DATA_C0 : S_DATA_C, 55 - i);
    fct_rx = 1'b1; cyc();
    chk("ovf50", 64'({credit_error, credit_count}), 64'({1'b1, 6'd50}));
    send_data(9'h0C6, 1'b1, S_DATA_C, 49);
    txwrite_tx = 1'b1; data_tx_i = 9'h1AB; cyc();
    fct_rx = 1'b1; char_done = 1'b1; cyc();
    chk("net_plus7", 64'({credit_error, credit_count}), 64'({1'b0, 6'd56}));
    chk("net_plus7_state", 64'(state_tx), 64'(S_DATA_C0));

    // asynchronous reset mid-character
    #2 reset_tx = 1'b1;
    #1;
    chk("async_rst_state", 64'(state_tx), 64'(S_START));
    chk("async_rst_outs", 64'({tx_char_data, tx_tcode, txrdy_tx, credit_count}), 64'(0));
    #2 reset_tx = 1'b0;

    // randomized run against the reference model
    link_mode = 2'd3;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) link_mode = 2'($urandom_range(0, 3));
      else if ($urandom_range(0, 49) == 0) link_mode = 2'd3;
      char_done     = ($urandom_range(0, 3) == 0);
      tickin_tx     = ($urandom_range(0, 9) == 0);
      timecode_tx_i = 8'($urandom);
      txwrite_tx    = ($urandom_range(0, 2) == 0);
      data_tx_i     = 9'($urandom);
      fct_owed_inc  = ($urandom_range(0, 11) == 0);
      fct_rx        = ($urandom_range(0, 14) == 0);
      @(posedge pclk_tx);
      #1;
      got_v = {state_tx, tx_char_data, tx_tcode, txrdy_tx, tickin_ack, credit_count, credit_error};
      exp_v = {kind_code(m.kind), m.dout, m.tout, (!m.dv && m.run), m.ack, m.credit[5:0], m.err};
      if (got_v !== exp_v && shown < 10) begin
        shown++;
        chk($sformatf("rand_cycle%0d", n), 64'(got_v), 64'(exp_v));
      end else begin
        checks++;
        if (got_v !== exp_v) failures++;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
